// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM and its ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EXEC   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CL_MEM     = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_ITYPE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_ILLEGAL = 3'd5
  } op_class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd8;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_EXT    = 2'd2;
  localparam logic [1:0] SRCB_EXT_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                                     op_class = CL_MEM;
      OP_RTYPE:                                         op_class = CL_RTYPE;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: op_class = CL_ITYPE;
      OP_BEQ, OP_BNE:                                   op_class = CL_BRANCH;
      OP_J:                                             op_class = CL_JUMP;
      default:                                          op_class = CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// Combinational ALU decoder: opcode/funct to alu_op, extender controls and illegal flag.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       ext_sign,
  output logic       ext_sel,
  output logic       illegal
);

  // Decode table; an R-type with an unknown funct is flagged illegal as well.
  always_comb begin
    alu_op   = ALU_ADD;
    ext_sign = 1'b1;
    ext_sel  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLL: begin
            alu_op  = ALU_SLL;
            ext_sel = 1'b1;
          end
          FN_SRL: begin
            alu_op  = ALU_SRL;
            ext_sel = 1'b1;
          end
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI:        alu_op = ALU_ADD;
      OP_SLTI:        alu_op = ALU_SLT;
      OP_ANDI: begin
        alu_op   = ALU_AND;
        ext_sign = 1'b0;
      end
      OP_ORI: begin
        alu_op   = ALU_OR;
        ext_sign = 1'b0;
      end
      OP_XORI: begin
        alu_op   = ALU_XOR;
        ext_sign = 1'b0;
      end
      OP_LUI: begin
        alu_op   = ALU_LUI;
        ext_sign = 1'b0;
      end
      OP_LW, OP_SW:   alu_op = ALU_ADD;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_J:           alu_op = ALU_ADD;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS core (fetch/decode/execute/memory/writeback).
// Optional performance counters cyc_cnt/retired_cnt are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ext_sign,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;

  logic [3:0] dec_alu_op;
  logic       dec_ext_sign;
  logic       dec_ext_sel;
  logic       dec_illegal;

  mc_alu_dec u_alu_dec (
    .opcode   (opcode_q),
    .funct    (funct_q),
    .alu_op   (dec_alu_op),
    .ext_sign (dec_ext_sign),
    .ext_sel  (dec_ext_sel),
    .illegal  (dec_illegal)
  );

  // State, reset-hold counter and latched instruction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 4'd0;
      opcode_q   <= 6'd0;
      funct_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
    end
  end

  // Next-state and control outputs; only mem_ready (FETCH) and zero (BRANCH) are Mealy terms.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_sign   = 1'b0;
    ext_sel    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_FETCH;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        opcode_d  = opcode;
        funct_d   = funct;
        alu_src_b = SRCB_EXT_SH;
        ext_sign  = 1'b1;
        case (op_class(opcode))
          CL_MEM:    state_d = ST_MEM_ADDR;
          CL_RTYPE:  state_d = ST_R_EXEC;
          CL_ITYPE:  state_d = ST_I_EXEC;
          CL_BRANCH: state_d = ST_BRANCH;
          CL_JUMP:   state_d = ST_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        ext_sign  = 1'b1;
        state_d   = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
        ext_sel   = dec_ext_sel;
        alu_src_b = dec_ext_sel ? SRCB_EXT : SRCB_REG;
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_R_WB;
        end
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        ext_sign  = dec_ext_sign;
        alu_op    = dec_alu_op;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = ((opcode_q == OP_BEQ) & zero) | ((opcode_q == OP_BNE) & ~zero);
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_dbg = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if (state_q != ST_IDLE) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_IDLE) && !illegal) begin
      retired_cnt_d = retired_cnt_q + 32'd1;
    end else begin
      retired_cnt_d = retired_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q     <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cyc_cnt     = cyc_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm: per-cycle expected control vectors are queued and compared.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, ext_sign, ext_sel, alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .ext_sign(ext_sign), .ext_sel(ext_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, ext_sign, ext_sel, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal;
  } ov_t;

  ov_t got;
  assign got = {state_dbg, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                reg_write, reg_dst, mem_to_reg, ext_sign, ext_sel, alu_src_a,
                alu_src_b, alu_op, illegal};

  ov_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Expected vectors, one per state, built from the control tables.
  function automatic ov_t e_fetch(input logic r);
    ov_t e = '0;
    e.st = 4'd1; e.mem_req = 1'b1; e.ir_write = r; e.pc_write = r; e.alu_src_b = 2'd1;
    return e;
  endfunction
  function automatic ov_t e_decode(input logic ill);
    ov_t e = '0;
    e.st = 4'd2; e.alu_src_b = 2'd3; e.ext_sign = 1'b1; e.illegal = ill;
    return e;
  endfunction
  function automatic ov_t e_iexec(input logic es, input logic [3:0] op);
    ov_t e = '0;
    e.st = 4'd9; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext_sign = es; e.alu_op = op;
    return e;
  endfunction
  function automatic ov_t e_iwb();
    ov_t e = '0;
    e.st = 4'd10; e.reg_write = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_rexec(input logic sel, input logic [1:0] asb, input logic [3:0] op, input logic ill);
    ov_t e = '0;
    e.st = 4'd7; e.alu_src_a = 1'b1; e.ext_sel = sel; e.alu_src_b = asb; e.alu_op = op; e.illegal = ill;
    return e;
  endfunction
  function automatic ov_t e_rwb();
    ov_t e = '0;
    e.st = 4'd8; e.reg_write = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_branch(input logic pcw);
    ov_t e = '0;
    e.st = 4'd11; e.alu_src_a = 1'b1; e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_write = pcw;
    return e;
  endfunction
  function automatic ov_t e_jump();
    ov_t e = '0;
    e.st = 4'd12; e.pc_write = 1'b1; e.pc_src = 2'd2;
    return e;
  endfunction
  function automatic ov_t e_maddr();
    ov_t e = '0;
    e.st = 4'd3; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext_sign = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mrd();
    ov_t e = '0;
    e.st = 4'd4; e.mem_req = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mwb();
    ov_t e = '0;
    e.st = 4'd5; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction
  function automatic ov_t e_mwr();
    ov_t e = '0;
    e.st = 4'd6; e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag);
    ov_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, got=%h", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s got=%h exp=%h", tag, got, e);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic rdy, input logic z, input ov_t e);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    zero      = 1'b0;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int waits, input logic ill);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, 1'b0, e_fetch(1'b0));
    cyc("fetch_ready", 1'b1, 1'b0, e_fetch(1'b1));
    cyc("decode", 1'b0, 1'b0, e_decode(ill));
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    exp_q.push_back('0);
    @(negedge clk);
    check("reset_idle");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi with three memory wait cycles
    fetch_decode(6'h08, 6'h00, 3, 1'b0);
    cyc("addi_iexec", 1'b0, 1'b0, e_iexec(1'b1, 4'd0));
    cyc("addi_iwb", 1'b0, 1'b0, e_iwb());
    // ori: zero-extend, OR
    fetch_decode(6'h0D, 6'h00, 0, 1'b0);
    cyc("ori_iexec", 1'b0, 1'b0, e_iexec(1'b0, 4'd3));
    cyc("ori_iwb", 1'b0, 1'b0, e_iwb());
    // lui
    fetch_decode(6'h0F, 6'h00, 0, 1'b0);
    cyc("lui_iexec", 1'b0, 1'b0, e_iexec(1'b0, 4'd8));
    cyc("lui_iwb", 1'b0, 1'b0, e_iwb());
    // sll: shamt path
    fetch_decode(6'h00, 6'h00, 0, 1'b0);
    cyc("sll_rexec", 1'b0, 1'b0, e_rexec(1'b1, 2'd2, 4'd6, 1'b0));
    cyc("sll_rwb", 1'b0, 1'b0, e_rwb());
    // sub
    fetch_decode(6'h00, 6'h22, 0, 1'b0);
    cyc("sub_rexec", 1'b0, 1'b0, e_rexec(1'b0, 2'd0, 4'd1, 1'b0));
    cyc("sub_rwb", 1'b0, 1'b0, e_rwb());
    // slt
    fetch_decode(6'h00, 6'h2A, 0, 1'b0);
    cyc("slt_rexec", 1'b0, 1'b0, e_rexec(1'b0, 2'd0, 4'd5, 1'b0));
    cyc("slt_rwb", 1'b0, 1'b0, e_rwb());
    // unknown funct
    fetch_decode(6'h00, 6'h3F, 0, 1'b0);
    cyc("badfn_rexec", 1'b0, 1'b0, e_rexec(1'b0, 2'd0, 4'd0, 1'b1));
    // branches
    fetch_decode(6'h04, 6'h00, 0, 1'b0);
    cyc("beq_taken", 1'b0, 1'b1, e_branch(1'b1));
    fetch_decode(6'h04, 6'h00, 0, 1'b0);
    cyc("beq_not", 1'b0, 1'b0, e_branch(1'b0));
    fetch_decode(6'h05, 6'h00, 0, 1'b0);
    cyc("bne_taken", 1'b0, 1'b0, e_branch(1'b1));
    fetch_decode(6'h05, 6'h00, 0, 1'b0);
    cyc("bne_not", 1'b0, 1'b1, e_branch(1'b0));
    // jump
    fetch_decode(6'h02, 6'h00, 0, 1'b0);
    cyc("jump", 1'b0, 1'b0, e_jump());
    // illegal opcode
    fetch_decode(6'h3F, 6'h00, 0, 1'b1);
    // lw with one read wait
    fetch_decode(6'h23, 6'h00, 0, 1'b0);
    cyc("lw_addr", 1'b0, 1'b0, e_maddr());
    cyc("lw_rd_wait", 1'b0, 1'b0, e_mrd());
    cyc("lw_rd", 1'b1, 1'b0, e_mrd());
    cyc("lw_wb", 1'b0, 1'b0, e_mwb());
    // sw zero-wait
    fetch_decode(6'h2B, 6'h00, 0, 1'b0);
    cyc("sw_addr", 1'b0, 1'b0, e_maddr());
    cyc("sw_wr", 1'b1, 1'b0, e_mwr());
    // lw interrupted by reset in MEM_RD
    fetch_decode(6'h23, 6'h00, 0, 1'b0);
    cyc("lw2_addr", 1'b0, 1'b0, e_maddr());
    mem_ready = 1'b0;
    exp_q.push_back(e_mrd());
    @(negedge clk);
    check("memrd_pre_reset");
    #1 rst_n = 1'b0;
    exp_q.push_back('0);
    #1 check("reset_mid_op");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("fetch_after_reset", 1'b0, 1'b0, e_fetch(1'b0));
    cyc("fetch_after_reset_rdy", 1'b1, 1'b0, e_fetch(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
